u_lsu: RTL

Load/store unit for the single-issue RV32I core. It sits directly downstream of the execute stage and upstream of the sram1 data port. It accepts one memory request at a time (byte address from the ALU, store data from rs2, funct3, destination register). It drives the byte-lane sram1 interface with registered strobes, then returns aligned, sign- or zero-extended load data as a register-file write-back. While an access is in flight it holds `busy` high so the hazard unit can stall the fetch and execute stages.

---
 rtl/lsu_pkg.sv | 68 ++++++
 rtl/u_lsu_align.sv | 36 +++
 rtl/u_lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   lsu_state_t  : FSM state encoding (IDLE, ACC, RSP)
//   lsu_size_t   : decoded access size (byte, half, word, illegal)
//   F3_*         : RV32I funct3 codes for loads/stores
//   decode_size  : funct3 + direction -> access size
//   lane_mask    : access size + address low bits -> sram1 byte enables
//   store_lanes  : access size + rs2 -> lane-replicated store data
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RSP  = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_ILL = 2'd3
   } lsu_size_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Unsigned variants only exist for loads; stores with f3 4/5 are illegal.
   function automatic lsu_size_t decode_size(input logic st, input logic [2:0] f3);
      lsu_size_t sz;
      case (f3)
         F3_B:    sz = SZ_B;
         F3_H:    sz = SZ_H;
         F3_W:    sz = SZ_W;
         F3_BU:   sz = st ? SZ_ILL : SZ_B;
         F3_HU:   sz = st ? SZ_ILL : SZ_H;
         default: sz = SZ_ILL;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] lane_mask(input lsu_size_t sz, input logic [1:0] adr_lo);
      logic [3:0] m;
      case (sz)
         SZ_B:    m = 4'b0001 << adr_lo;
         SZ_H:    m = adr_lo[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replicating the datum across lanes lets the byte enables alone pick
   // the destination, so no shifter is needed on the write path.
   function automatic logic [31:0] store_lanes(input lsu_size_t sz, input logic [31:0] wd);
      logic [31:0] d;
      case (sz)
         SZ_B:    d = {4{wd[7:0]}};
         SZ_H:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/u_lsu_align.sv
// -----------------------------------------------------------------------------
// u_lsu_align
// Combinational load-data extraction: shifts the sram1 read word down by the
// byte offset and sign/zero-extends according to funct3.
//   dat_rd : raw 32-bit sram1 read word
//   adr    : byte offset within the word
//   f3     : load funct3 (anything not B/H/BU/HU passes the word through)
//   ld_d   : aligned, extended write-back data
// -----------------------------------------------------------------------------
module u_lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] dat_rd,
   input  logic [1:0]  adr,
   input  logic [2:0]  f3,
   output logic [31:0] ld_d
);

   logic [31:0] sh;

   // Word accesses always have offset 0 here, so the shifted value is the
   // raw word for them too.
   assign sh = dat_rd >> {adr, 3'b000};

   always_comb begin
      ld_d = sh;
      case (f3)
         F3_B:    ld_d = {{24{sh[7]}}, sh[7:0]};
         F3_BU:   ld_d = {24'h0, sh[7:0]};
         F3_H:    ld_d = {{16{sh[15]}}, sh[15:0]};
         F3_HU:   ld_d = {16'h0, sh[15:0]};
         default: ld_d = sh;
      endcase
   end

endmodule

// File: rtl/u_lsu.sv
// -----------------------------------------------------------------------------
// u_lsu
// Load/store unit between the execute stage and the sram1 data port. Accepts
// one request at a time, issues registered byte-lane strobes, and returns
// aligned/extended load data as a register-file write-back.
//
// Optional feature macro: LSU_EXC_EN
//   defined   : misaligned / illegal-funct3 detection, exc_* outputs live
//   undefined : no detection, exc_* tied 0, address low bits masked per size,
//               illegal funct3 treated as a word access
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_v/req_rdy                    request handshake (accept on req_v & req_rdy)
//   req_st, req_f3, req_adr,
//   req_wd, req_rd_a                 request payload
//   flush                            kill of a request in IDLE or load in RSP
//   busy                             access in flight
//   dat_a, dat_we, dat_wd, dat_re    sram1 request (registered)
//   dat_rd                           sram1 read data, one cycle after dat_re
//   wb_v, wb_a, wb_d                 load write-back
//   exc_v, exc_cause, exc_adr        one-cycle exception report
//   fsm_state                        FSM state, for observation
//
// Handshake: a request transfers on a rising edge where req_v & req_rdy;
// req_rdy is high exactly in IDLE and does not depend on req_v.
// -----------------------------------------------------------------------------
module u_lsu
   import lsu_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_v,
   input  logic          req_st,
   input  logic [2:0]    req_f3,
   input  logic [31:0]   req_adr,
   input  logic [31:0]   req_wd,
   input  logic [4:0]    req_rd_a,
   output logic          req_rdy,
   input  logic          flush,
   output logic          busy,
   output logic [AW-1:0] dat_a,
   output logic [3:0]    dat_we,
   output logic [31:0]   dat_wd,
   output logic [3:0]    dat_re,
   input  logic [31:0]   dat_rd,
   output logic          wb_v,
   output logic [4:0]    wb_a,
   output logic [31:0]   wb_d,
   output logic          exc_v,
   output logic          exc_cause,
   output logic [31:0]   exc_adr,
   output logic [1:0]    fsm_state
);

   lsu_state_t  state;
   logic [1:0]  adr_lo_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_a_q;
   logic        st_q;

   lsu_size_t   sz;
   lsu_size_t   eff_sz;
   logic [1:0]  eff_lo;
   logic [2:0]  eff_f3;
   logic        exc_hit;
   logic [31:0] ld_d;

   assign sz = decode_size(req_st, req_f3);

`ifdef LSU_EXC_EN
   logic        illegal;
   logic        misal;
   logic        exc_v_q;
   logic        exc_cause_q;
   logic [31:0] exc_adr_q;

   assign illegal = (sz == SZ_ILL);
   assign misal   = ((sz == SZ_H) && req_adr[0]) ||
                    ((sz == SZ_W) && (req_adr[1:0] != 2'b00));
   assign exc_hit = illegal | misal;
   assign eff_sz  = sz;
   assign eff_f3  = req_f3;
   assign eff_lo  = req_adr[1:0];

   assign exc_v     = exc_v_q;
   assign exc_cause = exc_cause_q;
   assign exc_adr   = exc_adr_q;
`else
   logic unused_adr;

   assign exc_hit = 1'b0;
   assign eff_sz  = (sz == SZ_ILL) ? SZ_W : sz;
   assign eff_f3  = (sz == SZ_ILL) ? F3_W : req_f3;

   // Without exception checking, the offset is forced into alignment.
   always_comb begin
      eff_lo = 2'b00;
      case (eff_sz)
         SZ_B:    eff_lo = req_adr[1:0];
         SZ_H:    eff_lo = {req_adr[1], 1'b0};
         default: eff_lo = 2'b00;
      endcase
   end

   assign unused_adr = ^req_adr[31:AW+2];

   assign exc_v     = 1'b0;
   assign exc_cause = 1'b0;
   assign exc_adr   = 32'h0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         adr_lo_q <= 2'b00;
         f3_q     <= 3'd0;
         rd_a_q   <= 5'd0;
         st_q     <= 1'b0;
         dat_a    <= '0;
         dat_we   <= 4'h0;
         dat_wd   <= 32'h0;
         dat_re   <= 4'h0;
`ifdef LSU_EXC_EN
         exc_v_q     <= 1'b0;
         exc_cause_q <= 1'b0;
         exc_adr_q   <= 32'h0;
`endif
      end else begin
         // Strobes and store data are only ever live for the one ACC cycle.
         dat_we <= 4'h0;
         dat_wd <= 32'h0;
         dat_re <= 4'h0;
`ifdef LSU_EXC_EN
         exc_v_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req_v && !flush) begin
                  if (exc_hit) begin
`ifdef LSU_EXC_EN
                     exc_v_q     <= 1'b1;
                     exc_cause_q <= illegal;
                     exc_adr_q   <= req_adr;
`endif
                  end else begin
                     dat_a    <= req_adr[AW+1:2];
                     adr_lo_q <= eff_lo;
                     f3_q     <= eff_f3;
                     rd_a_q   <= req_rd_a;
                     st_q     <= req_st;
                     if (req_st) begin
                        dat_we <= lane_mask(eff_sz, eff_lo);
                        dat_wd <= store_lanes(eff_sz, req_wd);
                     end else begin
                        dat_re <= lane_mask(eff_sz, eff_lo);
                     end
                     state <= ST_ACC;
                  end
               end
            end
            // A store is committed once its strobe has been driven, so
            // flush has no effect here.
            ST_ACC:  state <= st_q ? ST_IDLE : ST_RSP;
            ST_RSP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   u_lsu_align u_align (
      .dat_rd (dat_rd),
      .adr    (adr_lo_q),
      .f3     (f3_q),
      .ld_d   (ld_d)
   );

   assign req_rdy   = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign wb_v      = (state == ST_RSP) && !flush && (rd_a_q != 5'd0);
   assign wb_a      = rd_a_q;
   assign wb_d      = (state == ST_RSP) ? ld_d : 32'h0;
   assign fsm_state = state;

endmodule
